// File: rtl/harris_window_gen_if.sv
// harris_window_gen_if: pixel stream in, 6x6 window with valid/count/frame_done out.
interface harris_window_gen_if;
   logic        pix_valid;
   logic [7:0]  pix_in;
   logic [7:0]  window [0:5][0:5];
   logic        win_valid;
   logic [63:0] count;
   logic        frame_done;
   modport master (output pix_valid, pix_in, input window, win_valid, count, frame_done);
   modport slave (input pix_valid, pix_in, output window, win_valid, count, frame_done);
endinterface

// File: rtl/harris_window_gen.sv
// harris_window_gen: buffers five lines of a raster pixel stream and emits a sliding 6x6 window.
module harris_window_gen #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input logic clk,
   input logic reset,
   harris_window_gen_if.slave win_if
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          last_col, last_row, win_valid_d, frame_done_d;
   logic          win_valid_q, frame_done_q;
   logic [63:0]   count_q, count_d;
   logic [7:0]    lb_q [0:4][0:IMG_W-1];
   logic [7:0]    win_q [0:5][0:5];
   logic [7:0]    vec [0:5];
   always_comb begin
      last_col     = col_q == CW'(IMG_W - 1);
      last_row     = row_q == RW'(IMG_H - 1);
      col_d        = last_col ? '0 : col_q + 1'b1;
      row_d        = !last_col ? row_q : (last_row ? '0 : row_q + 1'b1);
      count_d      = 64'(row_q) * 64'(IMG_W) + 64'(col_q);
      win_valid_d  = win_if.pix_valid && row_q >= RW'(5) && col_q >= CW'(5);
      frame_done_d = win_if.pix_valid && last_row && last_col;
      vec          = '{lb_q[0][col_q], lb_q[1][col_q], lb_q[2][col_q], lb_q[3][col_q], lb_q[4][col_q], win_if.pix_in};
   end
   // Line RAM is intentionally never cleared; win_valid masks the stale contents.
   always_ff @(posedge clk)
      if (!reset && win_if.pix_valid) begin
         for (int k = 0; k < 4; k++) lb_q[k][col_q] <= lb_q[k+1][col_q];
         lb_q[4][col_q] <= win_if.pix_in;
      end
   always_ff @(posedge clk)
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         count_q      <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) win_q[i][j] <= '0;
      end else begin
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         if (win_if.pix_valid) begin
            col_q   <= col_d;
            row_q   <= row_d;
            count_q <= count_d;
            for (int i = 0; i < 6; i++) begin
               for (int j = 0; j < 5; j++) win_q[i][j] <= win_q[i][j+1];
               win_q[i][5] <= vec[i];
            end
         end
      end
   assign win_if.window     = win_q;
   assign win_if.win_valid  = win_valid_q;
   assign win_if.count      = count_q;
   assign win_if.frame_done = frame_done_q;
endmodule

// File: doc/harris_window_gen.md
Name: harris_window_gen

Overview:
- Source end of the 6x6 pixel-window interface that the Sobel/Harris pipeline and its score monitor consume.
- Accepts a raster-order 8-bit pixel stream and buffers five previous image lines.
- Emits a 6x6 window with a valid strobe and the linear pixel index ("count") of the window's bottom-right pixel.
- Sits between the pixel source and the gradient stage; "count" is the index carried down to the score monitor.

Parameters:
- IMG_W, 64, image width in pixels; must be >= 6.
- IMG_H, 64, image height in lines; must be >= 6.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pix_valid  input  1  pix_in is valid this cycle; the pixel is accepted when high (no backpressure).
- pix_in  input  8  unsigned pixel, raster order, row-major.
- window  output  8 x [0:5][0:5]  unpacked array; [row][col]; [5][5] is the newest pixel.
- win_valid  output  1  window and count are valid this cycle.
- count  output  64  linear index (row*IMG_W+col) of window[5][5] in the current frame.
- frame_done  output  1  one-cycle pulse, registered with the last pixel of a frame.

Behaviour:
- Reset (synchronous, active-high):
  - col/row counters = 0.
  - win_valid, frame_done, count = 0.
  - Every window element = 0.
  - Line-buffer RAM is not cleared; stale data is masked by win_valid.
- Counters:
  - col runs 0..IMG_W-1 and advances only on an accepted pixel.
  - On col wrap, row advances 0..IMG_H-1.
  - On the last pixel of a frame (row=IMG_H-1, col=IMG_W-1), both counters wrap to 0.
- Line buffers: lb[0..4][0..IMG_W-1]; lb[0] holds the oldest line. On acceptance at column c:
  - New column vector, top to bottom, is {lb[0][c], lb[1][c], lb[2][c], lb[3][c], lb[4][c], pix_in}.
  - Then lb[k][c] <= lb[k+1][c] for k=0..3, and lb[4][c] <= pix_in.
- Window shift register, on acceptance:
  - window[i][j] <= window[i][j+1] for j=0..4.
  - window[i][5] <= new column vector[i].
  - When no pixel is accepted, the window holds its value.
- Outputs:
  - Latency: 1 cycle from acceptance to win_valid/window/count.
  - win_valid <= accepted && row>=5 && col>=5, using the accepted pixel's coordinates; otherwise 0 the next cycle.
  - count <= row*IMG_W+col of the accepted pixel, updated on every acceptance; meaningful only with win_valid.
  - Invariant when win_valid=1: window[i][j] = pixel at linear index count-(5-i)*IMG_W-(5-j).
  - frame_done <= accepted && row=IMG_H-1 && col=IMG_W-1. It coincides with the last win_valid of the frame.
- Boundary conditions:
  - Row wrap: window columns 0..4 hold the previous row's pixels until col>=5. No flush or stall; invalid windows are masked.
  - Gaps in pix_valid: any idle pattern gives identical window contents and counts to a continuous stream.
  - Frame wrap: the next frame starts at (0,0). The first five lines re-fill the buffers and the old frame's data never reaches a valid window.
  - Reset mid-frame: counters restart, and the next accepted pixel is (0,0) of a new frame.
  - Reset has priority over a simultaneous pix_valid; that pixel is dropped.
- Throughput: one window per cycle maximum. Windows per frame = (IMG_W-5)*(IMG_H-5).

Test Plan:
- All tests use IMG_W=8, IMG_H=8, pixel value = linear index mod 256 unless stated.
- Reset: hold reset 3 cycles with pix_valid=1 -> win_valid=0, frame_done=0, count=0, all window elements 0 during and 1 cycle after.
- First window: stream 64 pixels continuously -> first win_valid 1 cycle after pixel 45 with count=45, window[0][0]=0, window[0][5]=5, window[5][0]=40, window[5][5]=45.
- Window count and invariant: over the frame exactly 9 win_valid pulses, counts {45,46,47,53,54,55,61,62,63}. Every window satisfies window[i][j]=count-8*(5-i)-(5-j). No win_valid for col<5 or row<5.
- Bubbles: same frame with random pix_valid idles (about 50%) -> the identical 9 (count, window) pairs in order. win_valid is never high on a cycle following a non-accepted cycle.
- Frame wrap: send a second frame with values 64+index -> frame_done pulses once with count=63. The second frame's first window has count=45, window[0][0]=64, window[5][5]=109, with no first-frame pixel in any valid window.
- Mid-frame reset: after 20 pixels assert reset for 1 cycle, then stream a full frame -> first win_valid follows the 46th post-reset pixel with count=45. Exactly 9 windows, and frame_done follows the 64th post-reset pixel.
